// File: rtl/lenet_image_feeder_pkg.sv
// ---------------------------------------------------------------------------
// lenet_image_feeder_pkg : shared width macro and FSM encodings   (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none
`ifndef WD
`define WD 8
`endif

package lenet_image_feeder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

endpackage

`default_nettype wire

// File: rtl/lenet_image_feeder_if.sv
// ---------------------------------------------------------------------------
// lenet_image_feeder_if : host stream, accelerator port and result bundle (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none
`ifndef WD
`define WD 8
`endif

interface lenet_image_feeder_if #(
  parameter int WIDTH = `WD,
  parameter int AW    = 10
);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             go;
  logic [AW-1:0]    aa_image;
  logic             cena_image;
  logic [WIDTH-1:0] conv1_image;
  logic             ready;
  logic [3:0]       digit;
  logic             res_valid;
  logic [3:0]       res_digit;
  logic             res_ready;

  modport master (
    output s_valid, s_data, aa_image, cena_image, ready, digit, res_ready,
    input  s_ready, go, conv1_image, res_valid, res_digit
  );

  modport slave (
    input  s_valid, s_data, aa_image, cena_image, ready, digit, res_ready,
    output s_ready, go, conv1_image, res_valid, res_digit
  );
endinterface

`default_nettype wire

// File: rtl/lenet_image_feeder_image_ram.sv
// ---------------------------------------------------------------------------
// image_ram : single-port synchronous RAM with registered, holding read data (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module image_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             we_i,
  input  wire logic             re_i,
  input  wire logic [AW-1:0]    addr_i,
  input  wire logic [WIDTH-1:0] wdata_i,
  output      logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Array itself is never reset so it maps onto plain block RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/lenet_image_feeder.sv
// ---------------------------------------------------------------------------
// lenet_image_feeder : buffers one frame, starts the accelerator, captures result (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none
`ifndef WD
`define WD 8
`endif

module lenet_image_feeder
  import lenet_image_feeder_pkg::*;
#(
  parameter int WIDTH = `WD,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  input  wire logic           clear,
  output      logic           busy,
  lenet_image_feeder_if.slave bus
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   wcnt_q, wcnt_d;
  logic            go_q, go_d;
  logic            res_valid_q, res_valid_d;
  logic [3:0]      res_digit_q, res_digit_d;
  logic            accept;
  logic            ram_re;
  logic [AW-1:0]   ram_addr;

  assign accept   = (state_q == LOAD) && bus.s_valid && !clear;
  assign ram_re   = !bus.cena_image && (state_q == RUN);
  assign ram_addr = (state_q == RUN) ? bus.aa_image : wcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      go_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_digit_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      go_q        <= go_d;
      res_valid_q <= res_valid_d;
      res_digit_q <= res_digit_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    go_d        = 1'b0;
    res_valid_d = res_valid_q;
    res_digit_d = res_digit_q;
    case (state_q)
      IDLE: begin
        wcnt_d  = '0;
        state_d = LOAD;
      end
      LOAD: begin
        if (accept) begin
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == LAST_ADDR) begin
            state_d = RUN;
            go_d    = 1'b1;
          end
        end
      end
      RUN: begin
        // A done coinciding with the go pulse cannot belong to this frame.
        if (bus.ready && !go_q) begin
          res_digit_d = bus.digit;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready && res_valid_q) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d     = IDLE;
      wcnt_d      = '0;
      go_d        = 1'b0;
      res_valid_d = 1'b0;
    end
  end

  image_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_image_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (accept),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (bus.s_data),
    .rdata_o (bus.conv1_image)
  );

  assign bus.s_ready   = (state_q == LOAD);
  assign bus.go        = go_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_digit = res_digit_q;
  assign busy          = (state_q == RUN);

endmodule

`default_nettype wire

// File: tb/tb_lenet_image_feeder.sv
// ---------------------------------------------------------------------------
// tb_lenet_image_feeder : randomized frame loads checked against a frame-array model (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none
`ifndef WD
`define WD 8
`endif

module tb_lenet_image_feeder;
  import lenet_image_feeder_pkg::*;

  localparam int WIDTH = `WD;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  lenet_image_feeder_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  lenet_image_feeder #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .busy  (busy),
    .bus   (bus)
  );

  int               n_cmp = 0;
  int               n_err = 0;
  int               go_cnt = 0;
  bit               res_seen = 1'b0;
  logic [WIDTH-1:0] ref_mem [DEPTH];
  logic [WIDTH-1:0] exp_rd [$];
  logic [3:0]       exp_res [$];
  logic [WIDTH-1:0] last_rd = '0;
  logic [WIDTH-1:0] mon_e;
  logic [3:0]       dig_b;
  int               cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) if (bus.go === 1'b1) go_cnt++;

  // Read scoreboard: every enabled read issued in RUN has an expected word queued.
  always @(posedge clk) begin
    if (rst_n && bus.cena_image === 1'b0 && exp_rd.size() != 0) begin
      mon_e = exp_rd.pop_front();
      #1;
      check("read_data", bus.conv1_image, mon_e);
    end
  end

  // Result scoreboard: each rising res_valid must match a queued digit.
  always @(negedge clk) begin
    if (bus.res_valid === 1'b1 && !res_seen) begin
      res_seen = 1'b1;
      if (exp_res.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: res_valid=1 digit=%0d, none expected at %0t", bus.res_digit, $time);
      end else begin
        check("res_digit_capture", bus.res_digit, exp_res.pop_front());
      end
    end else if (bus.res_valid !== 1'b1) begin
      res_seen = 1'b0;
    end
  end

  task automatic load_pixels(input int n, input bit gaps, input bit pattern, input bit rdy_noise,
                             output int cycles);
    int k = 0;
    int stall = 0;
    logic v;
    logic [WIDTH-1:0] d;
    cycles = 0;
    while (k < n) begin
      @(negedge clk);
      v = gaps ? ($urandom_range(0, 99) < 70) : 1'b1;
      d = pattern ? WIDTH'(k & 'hFF) : WIDTH'($urandom);
      bus.s_valid = v;
      bus.s_data  = d;
      bus.ready   = rdy_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.digit   = 4'($urandom);
      cycles++;
      if (v && bus.s_ready === 1'b1) begin
        ref_mem[k] = d;
        k++;
        stall = 0;
      end else if (++stall > 100) begin
        n_cmp++;
        n_err++;
        $display("FAIL load_stall: accepted %0d of %0d pixels before timeout", k, n);
        return;
      end
    end
  endtask

  // Called right after the final pixel has been presented; its accept edge follows.
  task automatic expect_go(input int frames, input bit ready_in_go);
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.ready   = ready_in_go;
    bus.digit   = 4'd9;
    check("go_pulse", bus.go, 1);
    check("busy_at_go", busy, 1);
    check("s_ready_in_run", bus.s_ready, 0);
    @(negedge clk);
    bus.ready = 1'b0;
    check("go_single_cycle", bus.go, 0);
    check("go_count", go_cnt, frames);
    check("ready_with_go_ignored", bus.res_valid, 0);
    check("busy_in_run", busy, 1);
  endtask

  task automatic do_read(input int addr);
    @(negedge clk);
    bus.aa_image   = AW'(addr);
    bus.cena_image = 1'b0;
    exp_rd.push_back(ref_mem[addr]);
    last_rd = ref_mem[addr];
  endtask

  task automatic end_read();
    @(negedge clk);
    bus.cena_image = 1'b1;
    bus.aa_image   = AW'($urandom);
  endtask

  task automatic result(input logic [3:0] dg, input int hold_cycles);
    @(negedge clk);
    bus.ready = 1'b1;
    bus.digit = dg;
    exp_res.push_back(dg);
    @(negedge clk);
    bus.ready = 1'b0;
    bus.digit = ~dg;
    check("busy_drop", busy, 0);
    check("res_valid_set", bus.res_valid, 1);
    repeat (hold_cycles) begin
      @(negedge clk);
      check("res_hold_valid", bus.res_valid, 1);
      check("res_hold_digit", bus.res_digit, dg);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("res_valid_cleared", bus.res_valid, 0);
    check("idle_after_handshake", dut.state_q, ST_IDLE);
    check("s_ready_idle", bus.s_ready, 0);
    @(negedge clk);
    check("s_ready_reload", bus.s_ready, 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_valid    = 1'b0;
    bus.s_data     = '0;
    bus.aa_image   = '0;
    bus.cena_image = 1'b1;
    bus.ready      = 1'b0;
    bus.digit      = 4'd0;
    bus.res_ready  = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_state", dut.state_q, ST_IDLE);
    check("rst_wcnt", dut.wcnt_q, 0);
    check("rst_s_ready", bus.s_ready, 0);
    check("rst_go", bus.go, 0);
    check("rst_busy", busy, 0);
    check("rst_conv1", bus.conv1_image, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_digit", bus.res_digit, 0);
    rst_n = 1'b1;

    // Frame A: ramp pattern, valid held high
    load_pixels(DEPTH, 1'b0, 1'b1, 1'b0, cyc);
    check("load_cycles_back_to_back", cyc, DEPTH);
    expect_go(1, 1'b0);
    do_read(5);
    end_read();
    repeat (3) begin
      @(negedge clk);
      check("read_hold", bus.conv1_image, WIDTH'(5));
    end
    do_read(1023);
    end_read();
    check("read_last_addr", bus.conv1_image, WIDTH'(8'hFF));
    for (int i = 0; i < 10; i++) do_read($urandom_range(0, DEPTH - 1));
    end_read();
    result(4'd7, 10);

    // Aborted partial frame, then frame B with gaps and spurious ready
    load_pixels(300, 1'b1, 1'b0, 1'b1, cyc);
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.ready   = 1'b0;
    clear       = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_to_idle", dut.state_q, ST_IDLE);
    check("clear_wcnt", dut.wcnt_q, 0);
    check("clear_s_ready", bus.s_ready, 0);
    @(negedge clk);
    check("clear_then_load", dut.state_q, ST_LOAD);
    check("load_wcnt_zero", dut.wcnt_q, 0);
    bus.cena_image = 1'b0;
    bus.aa_image   = '0;
    @(negedge clk);
    bus.cena_image = 1'b1;
    check("read_outside_run_holds", bus.conv1_image, last_rd);
    check("load_ready_ignored", bus.res_valid, 0);

    load_pixels(DEPTH, 1'b1, 1'b0, 1'b1, cyc);
    expect_go(2, 1'b1);
    for (int a = 0; a < DEPTH; a++) do_read(a);
    end_read();
    dig_b = 4'($urandom_range(1, 15));
    result(dig_b, 3);

    // Frame C: reset in the middle of RUN
    load_pixels(DEPTH, 1'b0, 1'b1, 1'b0, cyc);
    expect_go(3, 1'b0);
    do_read(1023);
    end_read();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_go", bus.go, 0);
    check("mid_rst_s_ready", bus.s_ready, 0);
    check("mid_rst_conv1", bus.conv1_image, 0);
    check("mid_rst_res_valid", bus.res_valid, 0);
    check("mid_rst_res_digit", bus.res_digit, 0);
    check("mid_rst_state", dut.state_q, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_load", bus.s_ready, 1);
    check("post_rst_no_result", bus.res_valid, 0);

    check("read_queue_drained", exp_rd.size(), 0);
    check("result_queue_drained", exp_res.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
